enemy_missile_ctl: RTL and testbench

//  Enemy-side missile source: launches, moves and retires up to three enemy missiles and drives
//  en_x_missileN/en_y_missileN toward the ship block's collision detector and the missile renderer.

---
 rtl/enemy_missile_if.sv | 36 +++
 rtl/enemy_missile_ctl.sv | 154 +++++++++++++++
 tb/tb_enemy_missile_ctl.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/enemy_missile_if.sv
// rtl/enemy_missile_if.sv - shooter inputs and missile outputs of the enemy missile controller
interface enemy_missile_if;
    logic [10:0] shooter_x0;
    logic [10:0] shooter_x1;
    logic [10:0] shooter_x2;
    logic [10:0] shooter_y0;
    logic [10:0] shooter_y1;
    logic [10:0] shooter_y2;
    logic [2:0]  shooter_alive;
    logic        ship_dead;
    logic [10:0] en_x_missile1;
    logic [10:0] en_x_missile2;
    logic [10:0] en_x_missile3;
    logic [10:0] en_y_missile1;
    logic [10:0] en_y_missile2;
    logic [10:0] en_y_missile3;
    logic [2:0]  missile_on;

    modport master (
        output shooter_x0, shooter_x1, shooter_x2,
        output shooter_y0, shooter_y1, shooter_y2,
        output shooter_alive, ship_dead,
        input  en_x_missile1, en_x_missile2, en_x_missile3,
        input  en_y_missile1, en_y_missile2, en_y_missile3,
        input  missile_on
    );

    modport slave (
        input  shooter_x0, shooter_x1, shooter_x2,
        input  shooter_y0, shooter_y1, shooter_y2,
        input  shooter_alive, ship_dead,
        output en_x_missile1, en_x_missile2, en_x_missile3,
        output en_y_missile1, en_y_missile2, en_y_missile3,
        output missile_on
    );
endinterface

// File: rtl/enemy_missile_ctl.sv
// rtl/enemy_missile_ctl.sv - launches, moves and retires up to three enemy missiles
module enemy_missile_ctl #(
    parameter int unsigned STEP_DIV        = 650_000,
    parameter int unsigned SPEED           = 4,
    parameter int unsigned FIRE_BASE       = 16_250_000,
    parameter int unsigned Y_LIMIT         = 768,
    parameter int unsigned X_OFF           = 20,
    parameter int unsigned Y_OFF           = 32,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1,
    parameter int unsigned FIRE_RAND_SHIFT = 16
) (
    input logic            pclk,
    input logic            rst,
    enemy_missile_if.slave mif
);
    typedef enum logic {S_IDLE = 1'b0, S_FLYING = 1'b1} slot_state_e;

    slot_state_e state_q [3];
    slot_state_e state_d [3];
    logic [10:0] x_q [3];
    logic [10:0] x_d [3];
    logic [10:0] y_q [3];
    logic [10:0] y_d [3];
    logic [11:0] step_sum [3];

    logic [31:0] step_cnt_q, step_cnt_d;
    logic [31:0] fire_cnt_q, fire_cnt_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [1:0]  slot_ptr_q, slot_ptr_d;

    logic        step;
    logic        attempt;
    logic        launch;
    logic        launch_late;
    logic        ptr_idle;
    logic        sel_alive;
    logic [1:0]  shooter_sel;
    logic [10:0] sel_x, sel_y;
    logic [10:0] launch_x, launch_y;
    logic [31:0] fire_reload;

    assign step        = (step_cnt_q == STEP_DIV - 1);
    assign attempt     = (fire_cnt_q == 32'd0);
    assign fire_reload = FIRE_BASE + (32'(lfsr_q[7:0]) << FIRE_RAND_SHIFT);
    assign shooter_sel = (lfsr_q[1:0] == 2'd3) ? 2'd0 : lfsr_q[1:0];

    always_comb begin
        sel_x     = mif.shooter_x0;
        sel_y     = mif.shooter_y0;
        sel_alive = mif.shooter_alive[0];
        case (shooter_sel)
            2'd1: begin
                sel_x     = mif.shooter_x1;
                sel_y     = mif.shooter_y1;
                sel_alive = mif.shooter_alive[1];
            end
            2'd2: begin
                sel_x     = mif.shooter_x2;
                sel_y     = mif.shooter_y2;
                sel_alive = mif.shooter_alive[2];
            end
            default: ;
        endcase
    end

    always_comb begin
        ptr_idle = (state_q[0] == S_IDLE);
        case (slot_ptr_q)
            2'd1:    ptr_idle = (state_q[1] == S_IDLE);
            2'd2:    ptr_idle = (state_q[2] == S_IDLE);
            default: ;
        endcase
    end

    assign launch_x    = sel_x + 11'(X_OFF);
    assign launch_y    = sel_y + 11'(Y_OFF);
    // A launch that would already sit at/below the retire line never becomes visible.
    assign launch_late = ({1'b0, launch_y} >= 12'(Y_LIMIT));
    assign launch      = attempt && ptr_idle && sel_alive && !mif.ship_dead;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            step_sum[i] = {1'b0, y_q[i]} + 12'(SPEED);
        end
    end

    always_comb begin
        lfsr_d     = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        step_cnt_d = step ? 32'd0 : step_cnt_q + 32'd1;
        fire_cnt_d = attempt ? fire_reload : fire_cnt_q - 32'd1;
        slot_ptr_d = slot_ptr_q;
        if (attempt) begin
            slot_ptr_d = (slot_ptr_q == 2'd2) ? 2'd0 : slot_ptr_q + 2'd1;
        end
        for (int i = 0; i < 3; i++) begin
            state_d[i] = state_q[i];
            x_d[i]     = x_q[i];
            y_d[i]     = y_q[i];
            case (state_q[i])
                S_IDLE: begin
                    if (launch && (slot_ptr_q == 2'(i)) && !launch_late) begin
                        state_d[i] = S_FLYING;
                        x_d[i]     = launch_x;
                        y_d[i]     = launch_y;
                    end
                end
                S_FLYING: begin
                    if (step) begin
                        if (step_sum[i] >= 12'(Y_LIMIT)) begin
                            state_d[i] = S_IDLE;
                            x_d[i]     = 11'd0;
                            y_d[i]     = 11'd0;
                        end else begin
                            y_d[i] = step_sum[i][10:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            lfsr_q     <= LFSR_SEED;
            step_cnt_q <= 32'd0;
            fire_cnt_q <= FIRE_BASE;
            slot_ptr_q <= 2'd0;
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= S_IDLE;
                x_q[i]     <= 11'd0;
                y_q[i]     <= 11'd0;
            end
        end else begin
            lfsr_q     <= lfsr_d;
            step_cnt_q <= step_cnt_d;
            fire_cnt_q <= fire_cnt_d;
            slot_ptr_q <= slot_ptr_d;
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= state_d[i];
                x_q[i]     <= x_d[i];
                y_q[i]     <= y_d[i];
            end
        end
    end

    assign mif.en_x_missile1 = x_q[0];
    assign mif.en_x_missile2 = x_q[1];
    assign mif.en_x_missile3 = x_q[2];
    assign mif.en_y_missile1 = y_q[0];
    assign mif.en_y_missile2 = y_q[1];
    assign mif.en_y_missile3 = y_q[2];
    assign mif.missile_on    = {state_q[2] == S_FLYING, state_q[1] == S_FLYING, state_q[0] == S_FLYING};
endmodule

// File: tb/tb_enemy_missile_ctl.sv
// tb/tb_enemy_missile_ctl.sv - directed self-checking bench for enemy_missile_ctl
module tb_enemy_missile_ctl;
    localparam int YL = 768;

    logic pclk = 1'b0;
    logic rst  = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    enemy_missile_if mif();

    enemy_missile_ctl #(
        .STEP_DIV(4), .SPEED(4), .FIRE_BASE(10), .Y_LIMIT(YL), .X_OFF(20), .Y_OFF(32),
        .LFSR_SEED(16'hACE1), .FIRE_RAND_SHIFT(0)
    ) dut (
        .pclk(pclk),
        .rst (rst),
        .mif (mif)
    );

    always #5 pclk = ~pclk;

    int          sx [3];
    int          sy [3];
    logic [15:0] m_lfsr;
    int          m_fire, m_step, m_ptr;
    int          m_on [3];
    int          m_x [3];
    int          m_y [3];
    bit          ev_attempt, ev_step, ev_launch;
    int          ev_s, ev_slot;
    bit          ev_moved [3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] dut_x(input int i);
        case (i)
            0:       return mif.en_x_missile1;
            1:       return mif.en_x_missile2;
            default: return mif.en_x_missile3;
        endcase
    endfunction

    function automatic logic [10:0] dut_y(input int i);
        case (i)
            0:       return mif.en_y_missile1;
            1:       return mif.en_y_missile2;
            default: return mif.en_y_missile3;
        endcase
    endfunction

    task automatic drive_shooters(input int y);
        for (int i = 0; i < 3; i++) sy[i] = y;
        mif.shooter_x0 = 11'(sx[0]);
        mif.shooter_x1 = 11'(sx[1]);
        mif.shooter_x2 = 11'(sx[2]);
        mif.shooter_y0 = 11'(sy[0]);
        mif.shooter_y1 = 11'(sy[1]);
        mif.shooter_y2 = 11'(sy[2]);
    endtask

    // Advance one clock and update the expected schedule/slot picture for that edge.
    task automatic cyc();
        int ly, ny;
        @(posedge pclk);
        ev_attempt = 1'b0;
        ev_step    = 1'b0;
        ev_launch  = 1'b0;
        ev_slot    = m_ptr;
        for (int i = 0; i < 3; i++) ev_moved[i] = 1'b0;
        if (rst) begin
            m_lfsr = 16'hACE1;
            m_fire = 10;
            m_step = 0;
            m_ptr  = 0;
            for (int i = 0; i < 3; i++) begin
                m_on[i] = 0; m_x[i] = 0; m_y[i] = 0;
            end
        end else begin
            ev_step    = (m_step == 3);
            ev_attempt = (m_fire == 0);
            ev_s       = (int'(m_lfsr[1:0]) == 3) ? 0 : int'(m_lfsr[1:0]);
            for (int i = 0; i < 3; i++) begin
                if (ev_attempt && i == m_ptr && m_on[i] == 0 &&
                    mif.shooter_alive[ev_s] && !mif.ship_dead) begin
                    ly = (sy[ev_s] + 32) % 2048;
                    if (ly < YL) begin
                        m_on[i] = 1; m_x[i] = (sx[ev_s] + 20) % 2048; m_y[i] = ly;
                        ev_launch = 1'b1;
                    end
                end else if (ev_step && m_on[i] == 1) begin
                    ny = m_y[i] + 4;
                    if (ny >= YL) begin
                        m_on[i] = 0; m_x[i] = 0; m_y[i] = 0;
                    end else begin
                        m_y[i] = ny; ev_moved[i] = 1'b1;
                    end
                end
            end
            m_fire = ev_attempt ? 10 + int'(m_lfsr[7:0]) : m_fire - 1;
            m_step = ev_step ? 0 : m_step + 1;
            if (ev_attempt) m_ptr = (m_ptr + 1) % 3;
            m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
        end
        #1;
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_x%0d", tag, i), 32'(dut_x(i)), m_x[i]);
            chk($sformatf("%s_y%0d", tag, i), 32'(dut_y(i)), m_y[i]);
            chk($sformatf("%s_on%0d", tag, i), 32'(mif.missile_on[i]), m_on[i]);
        end
    endtask

    task automatic wait_attempt(input string tag);
        int n = 0;
        do begin cyc(); n++; end while (!ev_attempt && n < 400);
        if (!ev_attempt) begin
            checks++; failures++;
            $error("FAIL %s attempt_timeout observed=%0d expected<400", tag, n);
        end
    endtask

    task automatic wait_step(input string tag);
        int n = 0;
        do begin cyc(); n++; end while (!ev_step && n < 8);
        if (!ev_step) begin
            checks++; failures++;
            $error("FAIL %s step_timeout observed=%0d expected<8", tag, n);
        end
    endtask

    function automatic int flying();
        return m_on[0] + m_on[1] + m_on[2];
    endfunction

    initial begin
        int x0, py, hit, mover, n;
        int prev_y [3];
        sx = '{100, 200, 300};
        mif.shooter_alive = 3'b111;
        mif.ship_dead     = 1'b0;
        drive_shooters(728);

        // reset, then idle until the first attempt
        rst = 1'b1;
        repeat (3) cyc();
        check_all("t1_rst");
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cyc();
            chk("t1_idle_on", 32'(mif.missile_on), 32'd0);
        end

        // first attempt launches slot 0, one step, then retire without showing y=768
        cyc();
        x0 = 100 * (ev_s + 1) + 20;
        chk("t2_launch_on", 32'(mif.missile_on), 32'b001);
        chk("t2_launch_x", 32'(mif.en_x_missile1), x0);
        chk("t2_launch_y", 32'(mif.en_y_missile1), 760);
        check_all("t2_launch");
        wait_step("t2_step1");
        chk("t2_step1_y", 32'(mif.en_y_missile1), 764);
        chk("t2_step1_x", 32'(mif.en_x_missile1), x0);
        wait_step("t2_step2");
        chk("t2_retire_on", 32'(mif.missile_on), 32'd0);
        chk("t2_retire_x", 32'(mif.en_x_missile1), 32'd0);
        chk("t2_retire_y", 32'(mif.en_y_missile1), 32'd0);

        // dead shooters: attempts still rotate the slot pointer 1 -> 2 -> 0
        mif.shooter_alive = 3'b000;
        wait_attempt("t3_a1");
        chk("t3_a1_on", 32'(mif.missile_on), 32'd0);
        wait_attempt("t3_a2");
        chk("t3_a2_on", 32'(mif.missile_on), 32'd0);
        mif.shooter_alive = 3'b111;
        drive_shooters(0);
        wait_attempt("t3_a3");
        chk("t3_slot0_on", 32'(mif.missile_on), 32'b001);
        chk("t3_slot0_x", 32'(mif.en_x_missile1), 100 * (ev_s + 1) + 20);
        chk("t3_slot0_y", 32'(mif.en_y_missile1), 32);
        check_all("t3");

        // ship_dead blocks launches but the flying missile keeps going
        mif.ship_dead = 1'b1;
        wait_attempt("t4_a");
        chk("t4_blocked_on", 32'(mif.missile_on), 32'b001);
        check_all("t4_a");
        py = m_y[0];
        wait_step("t4_step");
        chk("t4_step_y", 32'(mif.en_y_missile1), py + 4);
        n = 0;
        while (m_on[0] == 1 && n < 1000) begin
            cyc(); n++;
            if (ev_step || ev_attempt) check_all("t4_fly");
        end
        chk("t4_retired_on", 32'(mif.missile_on), 32'd0);
        chk("t4_retired_y", 32'(mif.en_y_missile1), 32'd0);

        // launch y exactly at the limit is dropped; one pixel above flies for one step
        mif.ship_dead = 1'b0;
        drive_shooters(736);
        wait_attempt("t7_a768");
        chk("t7_y768_on", 32'(mif.missile_on), 32'd0);
        drive_shooters(735);
        wait_attempt("t7_a767");
        chk("t7_y767_on", 32'(mif.missile_on), 32'(1 << ev_slot));
        chk("t7_y767_y", 32'(dut_y(ev_slot)), 767);
        wait_step("t7_step");
        chk("t7_retire_on", 32'(mif.missile_on), 32'd0);

        // a launch landing on a step edge while another slot flies
        drive_shooters(0);
        hit = 0;
        mover = 0;
        for (int k = 0; k < 20000 && hit == 0; k++) begin
            for (int j = 0; j < 3; j++) prev_y[j] = m_y[j];
            cyc();
            if (ev_step || ev_attempt) check_all("t5_run");
            if (ev_launch && ev_step) begin
                for (int j = 0; j < 3; j++) begin
                    if (ev_moved[j]) begin hit = 1; mover = j; end
                end
            end
        end
        if (hit == 0) begin
            checks++; failures++;
            $error("FAIL t5_coincide observed=none expected=launch_on_step");
        end else begin
            chk("t5_launch_x", 32'(dut_x(ev_slot)), sx[ev_s] + 20);
            chk("t5_launch_y", 32'(dut_y(ev_slot)), 32);
            chk("t5_launch_on", 32'(mif.missile_on[ev_slot]), 32'd1);
            chk("t5_move_y", 32'(dut_y(mover)), prev_y[mover] + 4);
            chk("t5_move_on", 32'(mif.missile_on[mover]), 32'd1);
        end

        // reset with two missiles up parks everything and restarts the LFSR
        n = 0;
        while (flying() < 2 && n < 20000) begin cyc(); n++; end
        chk("t6_pre_on_count", 32'(int'(mif.missile_on[0]) + int'(mif.missile_on[1]) +
            int'(mif.missile_on[2])), 32'd2);
        rst = 1'b1;
        cyc();
        chk("t6_rst_on", 32'(mif.missile_on), 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t6_rst_x%0d", i), 32'(dut_x(i)), 32'd0);
            chk($sformatf("t6_rst_y%0d", i), 32'(dut_y(i)), 32'd0);
        end
        drive_shooters(728);
        rst = 1'b0;
        repeat (10) cyc();
        chk("t6_idle_on", 32'(mif.missile_on), 32'd0);
        cyc();
        chk("t6_relaunch_on", 32'(mif.missile_on), 32'b001);
        chk("t6_relaunch_x", 32'(mif.en_x_missile1), x0);
        chk("t6_relaunch_y", 32'(mif.en_y_missile1), 760);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
